// File: rtl/fir_pwm_led_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_pwm_led_if
// Description : Sample bus from the FIR core into the PWM LED stage, plus the
//               PWM stage status outputs.
//               master : FIR side, drives in_valid/in_sample.
//               slave  : PWM stage, drives pwm_out/duty_q/period_start.
// Signals     : in_valid      sample strobe, one sample per high cycle
//               in_sample     signed filtered sample (DATA_W bits)
//               pwm_out       registered LED drive
//               duty_q        duty currently applied (PWM_BITS bits)
//               period_start  one-cycle pulse on the first cycle of a period
// Revision    : 1.0  initial release
// ============================================================================
interface fir_pwm_led_if #(
    parameter int DATA_W   = 16,
    parameter int PWM_BITS = 8
);
    logic                       in_valid;
    logic signed [DATA_W-1:0]   in_sample;
    logic                       pwm_out;
    logic        [PWM_BITS-1:0] duty_q;
    logic                       period_start;

    modport master (
        output in_valid,
        output in_sample,
        input  pwm_out,
        input  duty_q,
        input  period_start
    );

    modport slave (
        input  in_valid,
        input  in_sample,
        output pwm_out,
        output duty_q,
        output period_start
    );
endinterface
`default_nettype wire

// File: rtl/fir_pwm_led.sv
`default_nettype none
// ============================================================================
// Module      : fir_pwm_led
// Description : Converts valid-qualified signed FIR output samples into a
//               glitch-free LED PWM. New duty values are held pending and only
//               applied on PWM period boundaries.
// Ports       : clk   clock, rising edge
//               rst   asynchronous active-high reset
//               bus   fir_pwm_led_if.slave (in_valid, in_sample, pwm_out,
//                     duty_q, period_start)
// Options     : FIR_PWM_ABS_EN  when defined, duty follows |in_sample|
//                               (most-negative value saturated) instead of
//                               the offset-binary value.
// Parameters  : DATA_W (> PWM_BITS+1), PWM_BITS, PRESCALE (>= 1)
// Revision    : 1.0  initial release
// ============================================================================
module fir_pwm_led #(
    parameter int DATA_W   = 16,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fir_pwm_led_if.slave  bus
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] pending_duty;
    logic                pending;
    logic                pwm;
    logic                period_start;

    logic                tick;
    logic                boundary;
    logic [PWM_BITS-1:0] new_duty;

    assign tick     = (pre == PRE_LAST);
    assign boundary = tick && (cnt == {PWM_BITS{1'b1}});

`ifdef FIR_PWM_ABS_EN
    // Magnitude, with the most-negative sample clamped to the largest
    // positive value so it maps to full scale instead of wrapping to zero.
    logic [DATA_W-1:0] mag;
    logic              unused_mag_bits;

    always_comb begin
        mag = bus.in_sample;
        if (bus.in_sample[DATA_W-1]) begin
            if (bus.in_sample == {1'b1, {(DATA_W-1){1'b0}}})
                mag = {1'b0, {(DATA_W-1){1'b1}}};
            else
                mag = DATA_W'(-bus.in_sample);
        end
    end

    // The sign bit of a magnitude is always zero, so duty starts one bit down.
    assign new_duty        = mag[DATA_W-2 -: PWM_BITS];
    assign unused_mag_bits = ^{mag[DATA_W-1], mag[DATA_W-2-PWM_BITS:0]};
`else
    // Offset binary: flipping the sign bit maps most-negative..most-positive
    // onto 0..full scale.
    logic [DATA_W-1:0] offs;
    logic              unused_offs_bits;

    assign offs             = bus.in_sample ^ {1'b1, {(DATA_W-1){1'b0}}};
    assign new_duty         = offs[DATA_W-1 -: PWM_BITS];
    assign unused_offs_bits = ^offs[DATA_W-1-PWM_BITS:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre          <= '0;
            cnt          <= '0;
            duty         <= '0;
            pending_duty <= '0;
            pending      <= 1'b0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (tick) begin
                pre <= '0;
                // Wraps to zero on the boundary tick by itself.
                cnt <= cnt + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end

            period_start <= boundary;

            // A sample landing on the boundary itself bypasses the pending
            // register and supersedes anything already pending.
            if (boundary && bus.in_valid) begin
                duty    <= new_duty;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                duty    <= pending_duty;
                pending <= 1'b0;
            end else if (bus.in_valid) begin
                pending_duty <= new_duty;
                pending      <= 1'b1;
            end

            // Compare on current values; the output is one cycle behind.
            pwm <= (cnt < duty);
        end
    end

    assign bus.pwm_out      = pwm;
    assign bus.duty_q       = duty;
    assign bus.period_start = period_start;

endmodule
`default_nettype wire
